// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: pulses jogar, then each round replays the stored
// sequence on botoes and appends one LFSR-generated move until done, aborted or told to err.
module jogador_automatico #(
    parameter int unsigned PULSO           = 20,
    parameter int unsigned INTERVALO       = 80,
    parameter int unsigned GAP_RODADA      = 200,
    parameter int unsigned ESPERA_INICIAL  = 2100,
    parameter logic [3:0]  PRIMEIRA_JOGADA = 4'b0001,
    parameter logic [3:0]  SEMENTE         = 4'b1001
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       ganhou,
    input  logic       perdeu,
    input  logic [3:0] rodadas_alvo,
    input  logic [3:0] erro_rodada,
    output logic       jogar,
    output logic [3:0] botoes,
    output logic       ocupado,
    output logic       concluido,
    output logic [1:0] resultado,
    output logic [3:0] db_rodada,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        PULSO_JOGAR = 4'd1,
        ESPERA_INI  = 4'd2,
        PRESSIONA   = 4'd3,
        SOLTA       = 4'd4,
        FIM_RODADA  = 4'd5,
        ESPERA_RES  = 4'd6,
        FIM         = 4'd7
    } estado_t;

    estado_t     r_estado, w_estado;
    logic [15:0] r_cont, w_cont, w_limite;
    logic [3:0]  r_rodada, w_rodada;
    logic [3:0]  r_idx, w_idx;
    logic [3:0]  r_alvo, w_alvo;
    logic [3:0]  r_erro, w_erro;
    logic [3:0]  r_lfsr, w_lfsr;
    logic [3:0]  r_mem [16];
    logic        r_jogar, w_jogar;
    logic [3:0]  r_botoes, w_botoes;
    logic        r_ocupado, w_ocupado;
    logic        r_concluido, w_concluido;
    logic [1:0]  r_resultado, w_resultado;
    logic        w_we;
    logic [3:0]  w_waddr, w_wdata;
    logic [3:0]  w_nova;
    logic        w_ocupado_est;
    logic        w_fim_cont;

    always_comb begin
        case (r_estado)
            PULSO_JOGAR, PRESSIONA: w_limite = 16'(PULSO);
            ESPERA_INI:             w_limite = 16'(ESPERA_INICIAL);
            SOLTA:                  w_limite = 16'(INTERVALO);
            FIM_RODADA:             w_limite = 16'(GAP_RODADA);
            default:                w_limite = 16'hFFFF;
        endcase
    end

    assign w_fim_cont    = (r_cont == w_limite);
    assign w_nova        = 4'b0001 << r_lfsr[1:0];
    assign w_ocupado_est = (r_estado != INICIAL) && (r_estado != FIM);

    always_comb begin
        w_estado    = r_estado;
        w_rodada    = r_rodada;
        w_idx       = r_idx;
        w_alvo      = r_alvo;
        w_erro      = r_erro;
        w_lfsr      = r_lfsr;
        w_resultado = r_resultado;
        w_we        = 1'b0;
        w_waddr     = 4'd0;
        w_wdata     = 4'd0;
        // Any result from the game ends the run, whatever we were doing.
        if (w_ocupado_est && (ganhou || perdeu)) begin
            w_estado    = FIM;
            w_resultado = r_resultado | {ganhou, perdeu};
        end else begin
            unique case (r_estado)
                INICIAL, FIM: begin
                    if (iniciar) begin
                        w_estado    = PULSO_JOGAR;
                        w_rodada    = 4'd1;
                        w_idx       = 4'd0;
                        w_resultado = 2'b00;
                        w_alvo      = (rodadas_alvo == 4'd0) ? 4'd1 : rodadas_alvo;
                        w_erro      = erro_rodada;
                        w_we        = 1'b1;
                        w_waddr     = 4'd0;
                        w_wdata     = PRIMEIRA_JOGADA;
                    end
                end
                PULSO_JOGAR: if (w_fim_cont) w_estado = ESPERA_INI;
                ESPERA_INI:  if (w_fim_cont) w_estado = PRESSIONA;
                PRESSIONA:   if (w_fim_cont) w_estado = SOLTA;
                SOLTA: begin
                    if (w_fim_cont) begin
                        if (r_idx == r_rodada) begin
                            w_estado = FIM_RODADA;
                        end else if (r_idx == r_rodada - 4'd1) begin
                            if (r_rodada == r_erro) begin
                                w_estado = ESPERA_RES;
                            end else begin
                                w_estado = PRESSIONA;
                                w_idx    = r_rodada;
                                w_we     = 1'b1;
                                w_waddr  = r_rodada;
                                w_wdata  = w_nova;
                                w_lfsr   = {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
                            end
                        end else begin
                            w_estado = PRESSIONA;
                            w_idx    = r_idx + 4'd1;
                        end
                    end
                end
                FIM_RODADA: begin
                    if (w_fim_cont) begin
                        if (r_rodada == r_alvo) begin
                            w_estado = ESPERA_RES;
                        end else begin
                            w_estado = PRESSIONA;
                            w_rodada = r_rodada + 4'd1;
                            w_idx    = 4'd0;
                        end
                    end
                end
                ESPERA_RES: w_estado = ESPERA_RES;
                default:    w_estado = INICIAL;
            endcase
        end

        if (w_estado != r_estado) begin
            w_cont = 16'd1;
        end else if (r_cont != 16'hFFFF) begin
            w_cont = r_cont + 16'd1;
        end else begin
            w_cont = r_cont;
        end

        // A freshly generated move is not in memory yet, so drive it straight from the write port.
        w_jogar     = (w_estado == PULSO_JOGAR);
        w_botoes    = (w_estado == PRESSIONA) ? (w_we ? w_wdata : r_mem[w_idx]) : 4'd0;
        w_ocupado   = (w_estado != INICIAL) && (w_estado != FIM);
        w_concluido = (w_estado == FIM);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado    <= INICIAL;
            r_cont      <= 16'd0;
            r_rodada    <= 4'd1;
            r_idx       <= 4'd0;
            r_alvo      <= 4'd1;
            r_erro      <= 4'd0;
            r_lfsr      <= SEMENTE;
            r_jogar     <= 1'b0;
            r_botoes    <= 4'd0;
            r_ocupado   <= 1'b0;
            r_concluido <= 1'b0;
            r_resultado <= 2'b00;
        end else begin
            r_estado    <= w_estado;
            r_cont      <= w_cont;
            r_rodada    <= w_rodada;
            r_idx       <= w_idx;
            r_alvo      <= w_alvo;
            r_erro      <= w_erro;
            r_lfsr      <= w_lfsr;
            r_jogar     <= w_jogar;
            r_botoes    <= w_botoes;
            r_ocupado   <= w_ocupado;
            r_concluido <= w_concluido;
            r_resultado <= w_resultado;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= (i == 0) ? PRIMEIRA_JOGADA : 4'd0;
            end
        end else if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign jogar     = r_jogar;
    assign botoes    = r_botoes;
    assign ocupado   = r_ocupado;
    assign concluido = r_concluido;
    assign resultado = r_resultado;
    assign db_rodada = r_ocupado ? r_rodada : 4'd0;
    assign db_estado = r_estado;

endmodule
